mag_comp_serial_ctrl: RTL and testbench
=======================================

# mag_comp_serial_ctrl

Bit-serial controller that compares two WIDTH-bit unsigned operands using the team's shared 1-bit magnitude comparator. It latches both operands on `start` and presents one bit pair per cycle to the comparator, MSB first. It stops at the first unequal bit, or after the LSB, and reports L/G/E with a one-cycle `done` pulse. This is the multi-bit magnitude comparator built from the 1-bit comparator datapath: one comparator instance, time-shared across bit positions.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits; legal range is 2 or more.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: request a comparison; sampled at the rising edge of `clk`.
- `A`, in, WIDTH: operand A, unsigned; sampled only on the edge that accepts `start`.
- `B`, in, WIDTH: operand B, unsigned; sampled only on the edge that accepts `start`.
- `cmp_a`, out, 1: bit of A presented to the external 1-bit comparator.
- `cmp_b`, out, 1: bit of B presented to the external 1-bit comparator.
- `cmp_l`, in, 1: comparator output L, meaning `cmp_a` < `cmp_b`.
- `cmp_g`, in, 1: comparator output G, meaning `cmp_a` > `cmp_b`.
- `cmp_e`, in, 1: comparator output E, meaning `cmp_a` == `cmp_b`.
- `busy`, out, 1: high while in SCAN.
- `done`, out, 1: one-cycle pulse when a result becomes valid.
- `L`, out, 1: registered result, A < B.
- `G`, out, 1: registered result, A > B.
- `E`, out, 1: registered result, A == B.
- `bits_used`, out, $clog2(WIDTH+1): number of bit positions examined for the last result.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE or DONE, with `start`=1: load shift registers `sa`←A and `sb`←B, bit counter ←0, clear L/G/E, go to SCAN. A new `start` is accepted in the DONE cycle, so comparisons can run back-to-back.
- IDLE or DONE, with `start`=0: DONE returns to IDLE; IDLE stays in IDLE.
- SCAN: `cmp_a`=`sa[WIDTH-1]` and `cmp_b`=`sb[WIDTH-1]`, driven combinationally from the registers. Every SCAN edge increments the counter and shifts `sa`/`sb` left by 1.
- SCAN, `cmp_e`=0: register L←`cmp_l` and G←`cmp_g`, set E←0, set `bits_used`←counter+1, go to DONE.
- SCAN, `cmp_e`=1 on the last bit (counter = WIDTH-1): set E←1, L←0, G←0, `bits_used`←WIDTH, go to DONE.
- SCAN, `cmp_e`=1 on any earlier bit: stay in SCAN.
- `start` during SCAN is ignored; the comparison in progress is not disturbed.
- `cmp_a` and `cmp_b` are 0 outside SCAN.
- `done`=1 exactly in the DONE state.
- L/G/E and `bits_used` hold their value after DONE until the next accepted `start`, which clears L/G/E to 0.
- Exactly one of L/G/E is high after any completed comparison.
- Comparator-input fault: if `cmp_e`=0 but `cmp_l`=`cmp_g`, the controller still terminates, with E=0. Verification flags this as an error; it is not corrected.

## Timing
- Reset (`rst_n`=0, asynchronous, at any time including mid-SCAN):
  - state → IDLE;
  - `busy`, `done`, L, G, E, `cmp_a`, `cmp_b` → 0;
  - `bits_used` → 0 and shift registers → 0.
- Operation resumes only on the first `start` seen at a rising edge after `rst_n` deasserts.
- Edge 0 accepts `start`. The comparison that examines n bits, with n between 1 and WIDTH, proceeds as:
  - `busy`=1 during cycles 1..n;
  - bit WIDTH-k is presented in cycle k;
  - `done`=1 in cycle n+1, with L/G/E valid from cycle n+1 onward.
- Latency from the `start` edge to `done` is n+1 cycles: minimum 2, maximum WIDTH+1.
- Throughput: a `start` held high continuously restarts in each DONE cycle, giving one result every n+1 cycles.

## Test plan
- WIDTH=8, A=0x80, B=0x7F, `start` pulse → mismatch on the MSB: `done` in cycle 2, G=1, L=0, E=0, `bits_used`=1, `busy` high for 1 cycle.
- A=0x5A, B=0x5A → E=1, L=G=0, `bits_used`=8, `done` in cycle 9, `busy` high for cycles 1..8. Check that `cmp_a` follows 0,1,0,1,1,0,1,0.
- A=0x12, B=0x13 → L=1, `bits_used`=8, `done` in cycle 9. Then, with `start` held high in the DONE cycle, A=0xFF and B=0x00 → G=1 with `done` 2 cycles later.
- Start A=0x0F, B=0x0E, then pulse `start` with A=0xF0, B=0x00 in cycle 3 → the second request is ignored: L=0, G=1, E=0 for the first operands, `bits_used`=8.
- Assert `rst_n`=0 asynchronously in cycle 4 of a comparison of A=0x01, B=0x01 → all outputs 0 immediately, with no `done` afterward. A fresh `start` after release completes normally with E=1.
- Randomized check, 1000 A/B pairs → L/G/E match A<B, A>B, A==B. `bits_used` = position of the first differing bit counted from the MSB, or 8 if A==B.

Source files
------------

// File: rtl/mag_comp_serial_ctrl.sv
// Bit-serial magnitude comparator controller: walks A/B MSB-first through one
// shared external 1-bit comparator and stops at the first unequal bit.
module mag_comp_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [WIDTH-1:0]               A,
  input  logic [WIDTH-1:0]               B,
  output logic                           cmp_a,
  output logic                           cmp_b,
  input  logic                           cmp_l,
  input  logic                           cmp_g,
  input  logic                           cmp_e,
  output logic                           busy,
  output logic                           done,
  output logic                           L,
  output logic                           G,
  output logic                           E,
  output logic [$clog2(WIDTH+1)-1:0]     bits_used
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa, r_sb;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_bits;
  logic             r_l, r_g, r_e;
  logic             w_scan;

  assign w_scan    = (r_state == SCAN);
  assign busy      = w_scan;
  assign done      = (r_state == DONE);
  // Comparator inputs are gated so the shared comparator sees 0/0 when idle.
  assign cmp_a     = w_scan & r_sa[WIDTH-1];
  assign cmp_b     = w_scan & r_sb[WIDTH-1];
  assign L         = r_l;
  assign G         = r_g;
  assign E         = r_e;
  assign bits_used = r_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_l     <= 1'b0;
      r_g     <= 1'b0;
      r_e     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_sa    <= A;
            r_sb    <= B;
            r_cnt   <= '0;
            r_l     <= 1'b0;
            r_g     <= 1'b0;
            r_e     <= 1'b0;
            r_state <= SCAN;
          end else begin
            r_state <= IDLE;
          end
        end
        SCAN: begin
          r_cnt <= r_cnt + CW'(1);
          r_sa  <= r_sa << 1;
          r_sb  <= r_sb << 1;
          if (!cmp_e) begin
            // A faulty comparator (l==g with e==0) still terminates here.
            r_l     <= cmp_l;
            r_g     <= cmp_g;
            r_e     <= 1'b0;
            r_bits  <= r_cnt + CW'(1);
            r_state <= DONE;
          end else if (r_cnt == LAST_BIT) begin
            r_l     <= 1'b0;
            r_g     <= 1'b0;
            r_e     <= 1'b1;
            r_bits  <= CW'(WIDTH);
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_comp_serial_ctrl.sv
// Directed and randomized bench for mag_comp_serial_ctrl (WIDTH=8) with a
// behavioural 1-bit comparator closing the loop.
module tb_mag_comp_serial_ctrl;

  logic       clk, rst_n, start;
  logic [7:0] a_in, b_in;
  logic       cmp_a, cmp_b, cmp_l, cmp_g, cmp_e;
  logic       busy, done, o_l, o_g, o_e;
  logic [3:0] bits_used;
  logic       fault_inj;

  int checks = 0;
  int errors = 0;

  mag_comp_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .B(b_in),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_l(cmp_l), .cmp_g(cmp_g), .cmp_e(cmp_e),
    .busy(busy), .done(done), .L(o_l), .G(o_g), .E(o_e), .bits_used(bits_used)
  );

  assign cmp_l = fault_inj ? 1'b0 : (~cmp_a &  cmp_b);
  assign cmp_g = fault_inj ? 1'b0 : ( cmp_a & ~cmp_b);
  assign cmp_e = fault_inj ? 1'b0 : ~(cmp_a ^ cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue start at a negedge; returns at the negedge of cycle 1.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; a_in = a; b_in = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; fault_inj = 1'b0;
    #12;
    checks++;
    if ({busy, done, o_l, o_g, o_e, cmp_a, cmp_b} !== 7'b0) begin
      errors++; $display("FAIL reset_outs got %b want 0000000", {busy, done, o_l, o_g, o_e, cmp_a, cmp_b});
    end
    checks++;
    if (bits_used !== 4'd0) begin errors++; $display("FAIL reset_bits got %0d want 0", bits_used); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL idle_after_reset got %b want 00", {busy, done}); end
  endtask

  task automatic test_msb_mismatch;
    launch(8'h80, 8'h7F);
    checks++;
    if ({busy, done, cmp_a, cmp_b} !== 4'b1010) begin
      errors++; $display("FAIL msb_c1 got %b want 1010", {busy, done, cmp_a, cmp_b});
    end
    @(negedge clk);
    checks++;
    if ({busy, done, o_l, o_g, o_e} !== 5'b01010 || bits_used !== 4'd1) begin
      errors++; $display("FAIL msb_c2 got %b bits %0d want 01010 bits 1", {busy, done, o_l, o_g, o_e}, bits_used);
    end
    @(negedge clk);
    checks++;
    if ({done, o_g} !== 2'b01) begin errors++; $display("FAIL msb_hold got %b want 01", {done, o_g}); end
  endtask

  task automatic test_equal;
    logic [7:0] pat;
    pat = 8'h5A;
    launch(8'h5A, 8'h5A);
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if ({busy, done, cmp_a} !== {1'b1, 1'b0, pat[8-k]}) begin
        errors++; $display("FAIL eq_cycle%0d got %b want %b", k, {busy, done, cmp_a}, {1'b1, 1'b0, pat[8-k]});
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done, o_l, o_g, o_e} !== 5'b01001 || bits_used !== 4'd8) begin
      errors++; $display("FAIL eq_c9 got %b bits %0d want 01001 bits 8", {busy, done, o_l, o_g, o_e}, bits_used);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    launch(8'h12, 8'h13);
    repeat (7) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_c8 got %b want 10", {busy, done}); end
    @(negedge clk);
    checks++;
    if ({done, o_l, o_g, o_e} !== 4'b1100 || bits_used !== 4'd8) begin
      errors++; $display("FAIL b2b_c9 got %b bits %0d want 1100 bits 8", {done, o_l, o_g, o_e}, bits_used);
    end
    start = 1'b1; a_in = 8'hFF; b_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done, o_l, o_g, o_e} !== 5'b10000) begin
      errors++; $display("FAIL b2b_c10 got %b want 10000", {busy, done, o_l, o_g, o_e});
    end
    @(negedge clk);
    checks++;
    if ({done, o_l, o_g, o_e} !== 4'b1010 || bits_used !== 4'd1) begin
      errors++; $display("FAIL b2b_c11 got %b bits %0d want 1010 bits 1", {done, o_l, o_g, o_e}, bits_used);
    end
  endtask

  task automatic test_start_ignored;
    @(negedge clk);
    launch(8'h0F, 8'h0E);
    @(negedge clk); @(negedge clk);
    start = 1'b1; a_in = 8'hF0; b_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin errors++; $display("FAIL ign_c4 got %b want 10", {busy, done}); end
    repeat (5) @(negedge clk);
    checks++;
    if ({done, o_l, o_g, o_e} !== 4'b1010 || bits_used !== 4'd8) begin
      errors++; $display("FAIL ign_c9 got %b bits %0d want 1010 bits 8", {done, o_l, o_g, o_e}, bits_used);
    end
  endtask

  task automatic test_async_reset;
    int seen;
    @(negedge clk);
    launch(8'h01, 8'h01);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, o_l, o_g, o_e, cmp_a, cmp_b} !== 7'b0 || bits_used !== 4'd0) begin
      errors++; $display("FAIL arst_now got %b bits %0d want 0000000 bits 0", {busy, done, o_l, o_g, o_e, cmp_a, cmp_b}, bits_used);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (done || busy) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL arst_quiet got %0d active cycles want 0", seen); end
    launch(8'h01, 8'h01);
    repeat (8) @(negedge clk);
    checks++;
    if ({done, o_l, o_g, o_e} !== 4'b1001 || bits_used !== 4'd8) begin
      errors++; $display("FAIL arst_redo got %b bits %0d want 1001 bits 8", {done, o_l, o_g, o_e}, bits_used);
    end
  endtask

  task automatic test_comparator_fault;
    @(negedge clk);
    fault_inj = 1'b1;
    launch(8'hA3, 8'hA3);
    @(negedge clk);
    checks++;
    if ({done, o_l, o_g, o_e} !== 4'b1000 || bits_used !== 4'd1) begin
      errors++; $display("FAIL fault got %b bits %0d want 1000 bits 1", {done, o_l, o_g, o_e}, bits_used);
    end
    fault_inj = 1'b0;
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    int n, cyc;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      b = (i % 8 == 0) ? a : 8'($urandom);
      n = 8;
      for (int j = 0; j < 8; j++) if (a[7-j] != b[7-j]) begin n = j + 1; break; end
      launch(a, b);
      cyc = 0;
      while (!done && cyc < 12) begin @(negedge clk); cyc++; end
      checks++;
      if (!done) begin
        errors++; $display("FAIL rnd_timeout a=%h b=%h", a, b);
      end else if ({o_l, o_g, o_e} !== {a < b, a > b, a == b} || bits_used !== 4'(n) || cyc != n) begin
        errors++;
        $display("FAIL rnd a=%h b=%h got lge=%b bits=%0d lat=%0d want lge=%b bits=%0d lat=%0d",
                 a, b, {o_l, o_g, o_e}, bits_used, cyc + 1, {a < b, a > b, a == b}, n, n + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_mismatch();
    test_equal();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    test_comparator_fault();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
